// File: rtl/my_mem_ctrl_pkg.sv
// Shared types and helpers for my_mem_ctrl.
// Holds the controller state encoding, the memory data/word widths and the
// even-parity check applied to words read back from the memory.
package my_mem_ctrl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWr,
    StRd,
    StResp
  } state_e;

  // 1 when the XOR over all word bits is 0. Written as an if so that an
  // unknown bit in simulation falls through to "not ok".
  function automatic logic even_parity_ok(input logic [WORD_W-1:0] word);
    if ((^word) == 1'b0) begin
      return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/my_mem_ctrl.sv
// Request-side controller for the parity-protected behavioural memory.
// Accepts single-beat read/write requests over valid/ready, holds the address
// and data stable for one cycle before raising a strobe, keeps mem_write high
// for WR_HOLD cycles or mem_read high for RD_WAIT cycles, and returns read
// data with an even-parity error flag and a saturating error count.
//
// Ports:
//   pclk, presetn               clock (rising edge), async active-low reset
//   req_valid/ready/write/addr/wdata   request handshake and payload
//   rsp_valid/rdata/perr        one-cycle read response, no backpressure
//   perr_count                  saturating count of read parity errors
//   mem_write/read/address/data_in     memory strobes, address, write data
//   mem_data_out                memory read word {parity, data}
module my_mem_ctrl
  import my_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_WAIT = 8,
  parameter int unsigned WR_HOLD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic [CNT_W-1:0]  perr_count,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [WORD_W-1:0] mem_data_out
);

  localparam int unsigned MaxWait = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
  localparam int unsigned TmrW    = $clog2(MaxWait + 1);

  state_e            r_state, w_state_d;
  logic [TmrW-1:0]   r_tmr, w_tmr_d;
  logic              r_write, w_write_d;
  logic              w_req_ready_d;
  logic              w_mem_write_d;
  logic              w_mem_read_d;
  logic [ADDR_W-1:0] w_mem_address_d;
  logic [DATA_W-1:0] w_mem_data_in_d;
  logic              w_rsp_valid_d;
  logic [DATA_W-1:0] w_rsp_rdata_d;
  logic              w_rsp_perr_d;
  logic [CNT_W-1:0]  w_perr_count_d;
  logic              w_accept;

  // req_ready is itself a register, so the first IDLE cycle after an
  // operation (and after reset) can never accept.
  assign w_accept = req_valid & req_ready;

  always_comb begin
    w_state_d       = r_state;
    w_tmr_d         = r_tmr;
    w_write_d       = r_write;
    w_req_ready_d   = 1'b0;
    w_mem_write_d   = 1'b0;
    w_mem_read_d    = 1'b0;
    w_mem_address_d = mem_address;
    w_mem_data_in_d = mem_data_in;
    w_rsp_valid_d   = 1'b0;
    w_rsp_rdata_d   = rsp_rdata;
    w_rsp_perr_d    = rsp_perr;
    w_perr_count_d  = perr_count;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_mem_address_d = req_addr;
          w_mem_data_in_d = req_wdata;
          w_write_d       = req_write;
          w_state_d       = StSetup;
        end else begin
          w_req_ready_d = 1'b1;
        end
      end
      StSetup: begin
        // Timer holds the number of strobe cycles still to go after this one.
        if (r_write) begin
          w_state_d     = StWr;
          w_mem_write_d = 1'b1;
          w_tmr_d       = TmrW'(WR_HOLD - 1);
        end else begin
          w_state_d    = StRd;
          w_mem_read_d = 1'b1;
          w_tmr_d      = TmrW'(RD_WAIT - 1);
        end
      end
      StWr: begin
        if (r_tmr == '0) begin
          w_state_d = StIdle;
        end else begin
          w_tmr_d       = r_tmr - TmrW'(1);
          w_mem_write_d = 1'b1;
        end
      end
      StRd: begin
        if (r_tmr == '0) begin
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
          w_rsp_rdata_d = mem_data_out[DATA_W-1:0];
          w_rsp_perr_d  = ~even_parity_ok(mem_data_out);
        end else begin
          w_tmr_d      = r_tmr - TmrW'(1);
          w_mem_read_d = 1'b1;
        end
      end
      StResp: begin
        w_state_d = StIdle;
        if (rsp_perr && !(&perr_count)) begin
          w_perr_count_d = perr_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= StIdle;
      r_tmr       <= '0;
      r_write     <= 1'b0;
      req_ready   <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      perr_count  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_tmr       <= w_tmr_d;
      r_write     <= w_write_d;
      req_ready   <= w_req_ready_d;
      mem_write   <= w_mem_write_d;
      mem_read    <= w_mem_read_d;
      mem_address <= w_mem_address_d;
      mem_data_in <= w_mem_data_in_d;
      rsp_valid   <= w_rsp_valid_d;
      rsp_rdata   <= w_rsp_rdata_d;
      rsp_perr    <= w_rsp_perr_d;
      perr_count  <= w_perr_count_d;
    end
  end

endmodule

// File: tb/tb_my_mem_ctrl.sv
// Self-checking bench for my_mem_ctrl: behavioural parity memory with a read
// latency, a read-response scoreboard, strobe timing monitors, and a second
// instance with a 2-bit error counter to observe saturation.
module tb_my_mem_ctrl;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned RD_WAIT = 8;
  localparam int unsigned WR_HOLD = 2;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_perr, mem_write, mem_read;
  logic [7:0]  rsp_rdata, mem_data_in;
  logic [15:0] perr_count, mem_address;
  logic [8:0]  mem_data_out;

  logic        d2_req_ready, d2_rsp_valid, d2_rsp_perr, d2_mem_write, d2_mem_read;
  logic [7:0]  d2_rsp_rdata, d2_mem_data_in;
  logic [1:0]  d2_perr_count;
  logic [15:0] d2_mem_address;

  always #5 pclk = ~pclk;

  my_mem_ctrl dut (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .perr_count(perr_count), .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  my_mem_ctrl #(.CNT_W(2)) dut2 (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_ready(d2_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata), .rsp_perr(d2_rsp_perr),
    .perr_count(d2_perr_count), .mem_write(d2_mem_write), .mem_read(d2_mem_read),
    .mem_address(d2_mem_address), .mem_data_in(d2_mem_data_in), .mem_data_out(mem_data_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Behavioural memory: stores {parity, data}; returns garbage until mem_read
  // has been high long enough, optionally with the parity bit flipped.
  logic [8:0] mem [0:65535];
  logic [7:0] exp_mem [0:65535];
  logic       corrupt = 1'b0;
  int         rd_cnt = 0;

  assign mem_data_out = !mem_read ? 9'h000 :
                        (rd_cnt < int'(RD_WAIT) - 1) ? 9'h1FF :
                        (mem[mem_address] ^ {corrupt, 8'h00});

  always @(posedge pclk) begin
    rd_cnt <= mem_read ? rd_cnt + 1 : 0;
    if (mem_write) mem[mem_address] <= {^mem_data_in, mem_data_in};
  end

  // Scoreboard state
  logic [8:0]  sb_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        acc_write = 1'b0;
  logic [15:0] acc_addr = '0;
  logic [7:0]  acc_data = '0;
  logic        inflight = 1'b0;
  int          n_wr_acc = 0, n_rd_acc = 0, n_wr_rise = 0, n_rd_rise = 0;
  int          exp_cnt = 0, exp_cnt2 = 0;
  logic        cnt_pend = 1'b0;
  logic        prev_ready = 1'b0;
  int          wr_run = 0, rd_run = 0;
  logic [8:0]  sb_want;
  int          sb_acc;

  always @(posedge pclk) begin
    cyc++;
    if (presetn && req_valid && req_ready) begin
      acc_cyc   = cyc;
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_data  = req_wdata;
      inflight  = 1'b1;
      if (req_write) begin
        exp_mem[req_addr] = req_wdata;
        n_wr_acc++;
      end else begin
        sb_q.push_back({corrupt, exp_mem[req_addr]});
        acc_q.push_back(cyc);
        n_rd_acc++;
      end
    end
  end

  always @(negedge pclk) begin
    if (!presetn) begin
      wr_run = 0; rd_run = 0;
      sb_q.delete(); acc_q.delete();
      inflight = 1'b0; cnt_pend = 1'b0; prev_ready = 1'b0;
      exp_cnt = 0; exp_cnt2 = 0;
    end else begin
      if (cnt_pend) begin
        check("perr_count", 32'(perr_count), exp_cnt);
        check("perr_count_cnt2", 32'(d2_perr_count), exp_cnt2);
        cnt_pend = 1'b0;
      end
      if (mem_write) begin
        if (wr_run == 0) begin
          n_wr_rise++;
          check("wr_rise_lat", cyc - acc_cyc, 1);
          check("wr_addr", 32'(mem_address), 32'(acc_addr));
          check("wr_data", 32'(mem_data_in), 32'(acc_data));
          check("wr_ready_low", 32'(req_ready), 0);
        end
        wr_run++;
      end else if (wr_run != 0) begin
        check("wr_hold", wr_run, WR_HOLD);
        wr_run = 0;
      end
      if (mem_read) begin
        if (rd_run == 0) begin
          n_rd_rise++;
          check("rd_rise_lat", cyc - acc_cyc, 1);
          check("rd_addr", 32'(mem_address), 32'(acc_addr));
          check("rd_ready_low", 32'(req_ready), 0);
        end
        rd_run++;
      end else if (rd_run != 0) begin
        check("rd_wait", rd_run, RD_WAIT);
        rd_run = 0;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          sb_want = sb_q.pop_front();
          sb_acc  = acc_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(sb_want[7:0]));
          check("rsp_perr", 32'(rsp_perr), 32'(sb_want[8]));
          check("rsp_lat", cyc - sb_acc, RD_WAIT + 1);
          if (sb_want[8]) begin
            if (exp_cnt != 65535) exp_cnt++;
            if (exp_cnt2 != 3) exp_cnt2++;
          end
          cnt_pend = 1'b1;
        end
      end
      if (req_ready && !prev_ready && inflight) begin
        check("ready_lat", cyc - acc_cyc, acc_write ? WR_HOLD + 2 : RD_WAIT + 3);
        inflight = 1'b0;
      end
      prev_ready = req_ready;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                        input logic hold);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge pclk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !req_ready || inflight || cnt_pend) && n < 300) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'(n), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_mem_read"}, 32'(mem_read), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 9'h000;
      exp_mem[i] = 8'h00;
    end

    // Reset state
    repeat (3) @(negedge pclk);
    check_all_zero("rst");
    check("rst_mem_address", 32'(mem_address), 0);
    check("rst_mem_data_in", 32'(mem_data_in), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_perr", 32'(rsp_perr), 0);
    check("rst_perr_count", 32'(perr_count), 0);
    presetn = 1'b1;
    @(negedge pclk);
    check("ready_after_rst", 32'(req_ready), 1);

    // Basic write then read
    do_req(1'b1, 16'h0010, 8'hA5, 1'b0);
    wait_idle();
    do_req(1'b0, 16'h0010, 8'h00, 1'b0);
    wait_idle();

    // Unwritten location
    do_req(1'b0, 16'h0123, 8'h00, 1'b0);
    wait_idle();
    check("perr_count_clean", 32'(perr_count), 0);

    // Bad parity word 0x1A5, then a good read
    corrupt = 1'b1;
    do_req(1'b0, 16'h0010, 8'h00, 1'b0);
    wait_idle();
    corrupt = 1'b0;
    check("perr_count_one", 32'(perr_count), 1);
    do_req(1'b0, 16'h0010, 8'h00, 1'b0);
    wait_idle();
    check("perr_count_still_one", 32'(perr_count), 1);

    // Three queued requests with req_valid held high
    do_req(1'b1, 16'h0001, 8'h3C, 1'b1);
    do_req(1'b1, 16'h0002, 8'hFF, 1'b1);
    do_req(1'b0, 16'h0001, 8'h00, 1'b0);
    wait_idle();

    // Reset during the 4th RD cycle
    do_req(1'b1, 16'h0040, 8'h5A, 1'b0);
    wait_idle();
    @(negedge pclk);
    do_req(1'b0, 16'h0040, 8'h00, 1'b0);
    repeat (4) @(posedge pclk);
    #1;
    check("mid_rd_strobe", 32'(mem_read), 1);
    #1;
    presetn = 1'b0;
    #1;
    check_all_zero("mid_rst");
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    check("ready_after_mid_rst", 32'(req_ready), 1);
    repeat (15) @(negedge pclk);
    do_req(1'b0, 16'h0040, 8'h00, 1'b0);
    wait_idle();

    // Five parity errors: full counter reaches 5, 2-bit counter stops at 3
    corrupt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_req(1'b0, 16'h0010, 8'h00, 1'b0);
      wait_idle();
    end
    corrupt = 1'b0;
    check("perr_count_five", 32'(perr_count), 5);
    check("perr_count_sat", 32'(d2_perr_count), 3);

    check("wr_rises", n_wr_rise, n_wr_acc);
    check("rd_rises", n_rd_rise, n_rd_acc);
    check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
